alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, lane width in bits.
REQ-002 The module SHALL have parameter VECTOR_SIZE, default 4, lanes per operand.
REQ-003 The module SHALL have parameter TAG_WIDTH, default 4, width of the request tag carried to the result.
REQ-004 The module SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 The module SHALL have port i_valid, input, 1, request present.
REQ-007 The module SHALL have port o_ready, output, 1, request accepted when high with i_valid.
REQ-008 The module SHALL have port i_opcode, input, 5, ALU operation.
REQ-009 The module SHALL have ports i_operand_a and i_operand_b, input, VECTOR_SIZE x DATA_WIDTH, packed lane operands.
REQ-010 The module SHALL have port i_tag, input, TAG_WIDTH, request identifier.
REQ-011 The module SHALL have port o_valid, output, 1, result present.
REQ-012 The module SHALL have port i_ready, input, 1, consumer takes the result when high with o_valid.
REQ-013 The module SHALL have port o_result, output, VECTOR_SIZE x DATA_WIDTH, lane results.
REQ-014 The module SHALL have port o_tag, output, TAG_WIDTH, tag of the request that produced o_result.
REQ-015 The module SHALL have port o_illegal, output, 1, result came from an unsupported opcode.
REQ-016 The module SHALL have port o_issue_count, output, 16, completed-result counter (see Configuration).

Function
REQ-017 Requests SHALL be accepted on a rising edge where i_valid && o_ready; results SHALL complete on a rising edge where o_valid && i_ready.
REQ-018 The datapath SHALL be two registered stages: S1 holds opcode, operands and tag; the combinational ALU reads S1; S2 holds result, tag and illegal flag.
REQ-019 Latency SHALL be 2 edges: a request accepted at edge k is presented on o_valid after edge k+1.
REQ-020 S2 SHALL load from S1 when S1 is valid and (S2 is empty or i_ready is high).
REQ-021 o_ready SHALL equal !s1_valid || !s2_valid || i_ready, giving one request per cycle when i_ready stays high.
REQ-022 While o_valid && !i_ready, o_result, o_tag and o_illegal SHALL hold stable.
REQ-023 Requests SHALL be processed in acceptance order, with no drop or duplication.
REQ-024 Supported opcodes SHALL be the following, all lane-wise, wrapping modulo 2^DATA_WIDTH with the low DATA_WIDTH bits kept:
- 00001 add
- 00010 sub
- 00011 mul
- 01001 and
- 01010 or
- 01011 xor
- 10001 pass a
- 10010 pass b
REQ-025 Any other opcode SHALL produce an all-zero result with o_illegal=1; it completes like a normal request and never stalls.
REQ-026 Simultaneous accept and complete in the same cycle SHALL both take effect, with no bubble.

Reset
REQ-027 Asserting i_rst_n low SHALL immediately clear s1_valid and s2_valid, set o_valid=0, o_result=0, o_tag=0, o_illegal=0 and o_issue_count=0.
REQ-028 o_ready SHALL be 1 while in reset and after reset.
REQ-029 In-flight requests at reset SHALL be discarded, and none SHALL appear after deassertion.

Configuration
REQ-030 With macro ALU_ISSUE_PERF_EN defined, o_issue_count SHALL increment on each completed result and saturate at 0xFFFF.
REQ-031 Without ALU_ISSUE_PERF_EN, o_issue_count SHALL be constant 0 and no counter flops SHALL be built.

Structure
REQ-032 A shared package alu_pkg SHALL hold the opcode enum (5-bit, the eight codes above) and a helper function identifying legal opcodes.
REQ-033 The combinational ALU SHALL be one instantiated sub-module, alu, driven from S1; alu_issue itself SHALL contain no arithmetic.

Verification
REQ-034 Reset, then add with a={1,2,3,4}, b={10,20,30,40}, tag 3, i_ready=1 -> result {11,22,33,44}, tag 3, o_illegal=0, two edges after accept.
REQ-035 sub with a lane 0=0, b lane 0=1 -> lane 0 = 0xFFFFFFFF; mul with 0x10000 x 0x10000 -> lane = 0.
REQ-036 Opcode 00111 with nonzero operands -> result 0, o_illegal=1, o_ready never drops because of it.
REQ-037 Back-to-back stream of 8 requests with tags 0..7, i_ready held low for 5 cycles -> o_ready=0 once both stages are full, outputs stable, then tags 0..7 delivered in order with no loss.
REQ-038 Assert i_rst_n low while both stages hold requests -> o_valid=0 at once; after release, no stale result appears.
REQ-039 With ALU_ISSUE_PERF_EN, 70000 completions -> o_issue_count=0xFFFF; without the macro, o_issue_count stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and a legality helper.
package alu_pkg;

  localparam int OPCODE_WIDTH = 5;

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00001,
    OP_SUB    = 5'b00010,
    OP_MUL    = 5'b00011,
    OP_AND    = 5'b01001,
    OP_OR     = 5'b01010,
    OP_XOR    = 5'b01011,
    OP_PASS_A = 5'b10001,
    OP_PASS_B = 5'b10010
  } opcode_e;

  // True for the eight supported operations, false for every other code.
  function automatic logic is_legal_op(input logic [4:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_MUL,
      OP_AND, OP_OR, OP_XOR,
      OP_PASS_A, OP_PASS_B: legal = 1'b1;
      default:              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational lane-wise vector ALU. Each lane wraps modulo 2^DATA_WIDTH;
// unsupported opcodes give an all-zero result and raise illegal.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int VECTOR_SIZE = 4
) (
  input  logic [4:0]                        opcode,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] operand_a,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] operand_b,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] result,
  output logic                              illegal
);

  assign illegal = ~is_legal_op(opcode);

  for (genvar g = 0; g < VECTOR_SIZE; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_a_s;
    logic [DATA_WIDTH-1:0] lane_b_s;
    logic [DATA_WIDTH-1:0] lane_r_s;

    assign lane_a_s = operand_a[g*DATA_WIDTH +: DATA_WIDTH];
    assign lane_b_s = operand_b[g*DATA_WIDTH +: DATA_WIDTH];

    // Per-lane operation select; results are truncated to the lane width.
    always_comb begin
      lane_r_s = '0;
      case (opcode)
        OP_ADD:    lane_r_s = lane_a_s + lane_b_s;
        OP_SUB:    lane_r_s = lane_a_s - lane_b_s;
        OP_MUL:    lane_r_s = lane_a_s * lane_b_s;
        OP_AND:    lane_r_s = lane_a_s & lane_b_s;
        OP_OR:     lane_r_s = lane_a_s | lane_b_s;
        OP_XOR:    lane_r_s = lane_a_s ^ lane_b_s;
        OP_PASS_A: lane_r_s = lane_a_s;
        OP_PASS_B: lane_r_s = lane_b_s;
        default:   lane_r_s = '0;
      endcase
    end

    assign result[g*DATA_WIDTH +: DATA_WIDTH] = lane_r_s;
  end

endmodule

// File: rtl/alu_issue.sv
// Two-stage valid/ready ALU issue pipeline.
//   S1 registers the accepted request, the alu sub-module computes from S1,
//   S2 registers result/tag/illegal and drives the outputs directly.
// Optional feature: define ALU_ISSUE_PERF_EN to build a saturating 16-bit
// completed-result counter on o_issue_count; otherwise it is tied to zero.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int VECTOR_SIZE = 4,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [4:0]                        i_opcode,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] i_operand_a,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] i_operand_b,
  input  logic [TAG_WIDTH-1:0]              i_tag,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] o_result,
  output logic [TAG_WIDTH-1:0]              o_tag,
  output logic                              o_illegal,
  output logic [15:0]                       o_issue_count
);

  localparam int VW = VECTOR_SIZE * DATA_WIDTH;

  logic                 s1_valid_r;
  logic [4:0]           s1_opcode_r;
  logic [VW-1:0]        s1_a_r;
  logic [VW-1:0]        s1_b_r;
  logic [TAG_WIDTH-1:0] s1_tag_r;

  logic                 s2_valid_r;
  logic [VW-1:0]        s2_result_r;
  logic [TAG_WIDTH-1:0] s2_tag_r;
  logic                 s2_illegal_r;

  logic [VW-1:0]        alu_result_s;
  logic                 alu_illegal_s;
  logic                 ready_s;
  logic                 accept_s;
  logic                 s2_load_s;
  logic                 complete_s;

  // S1 may take a new request whenever it is empty or is about to move into S2.
  assign ready_s    = ~s1_valid_r | ~s2_valid_r | i_ready;
  assign accept_s   = i_valid & ready_s;
  assign complete_s = s2_valid_r & i_ready;
  assign s2_load_s  = s1_valid_r & (~s2_valid_r | i_ready);

  alu #(
    .DATA_WIDTH  (DATA_WIDTH),
    .VECTOR_SIZE (VECTOR_SIZE)
  ) u_alu (
    .opcode    (s1_opcode_r),
    .operand_a (s1_a_r),
    .operand_b (s1_b_r),
    .result    (alu_result_s),
    .illegal   (alu_illegal_s)
  );

  // Stage 1: capture accepted request; empties when it advances with no refill.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_opcode_r <= 5'b00000;
      s1_a_r      <= '0;
      s1_b_r      <= '0;
      s1_tag_r    <= '0;
    end else begin
      if (accept_s) begin
        s1_valid_r  <= 1'b1;
        s1_opcode_r <= i_opcode;
        s1_a_r      <= i_operand_a;
        s1_b_r      <= i_operand_b;
        s1_tag_r    <= i_tag;
      end else if (s2_load_s) begin
        s1_valid_r  <= 1'b0;
      end
    end
  end

  // Stage 2: capture ALU output; holds while the consumer stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_r   <= 1'b0;
      s2_result_r  <= '0;
      s2_tag_r     <= '0;
      s2_illegal_r <= 1'b0;
    end else begin
      if (s2_load_s) begin
        s2_valid_r   <= 1'b1;
        s2_result_r  <= alu_result_s;
        s2_tag_r     <= s1_tag_r;
        s2_illegal_r <= alu_illegal_s;
      end else if (complete_s) begin
        s2_valid_r   <= 1'b0;
      end
    end
  end

  assign o_ready   = ready_s;
  assign o_valid   = s2_valid_r;
  assign o_result  = s2_result_r;
  assign o_tag     = s2_tag_r;
  assign o_illegal = s2_illegal_r;

`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] issue_count_r;

  // Count completed results, sticking at the maximum value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      issue_count_r <= 16'h0000;
    end else begin
      if (complete_s && (issue_count_r != 16'hFFFF)) begin
        issue_count_r <= issue_count_r + 16'h0001;
      end
    end
  end

  assign o_issue_count = issue_count_r;
`else
  assign o_issue_count = 16'h0000;
`endif

endmodule
